pool_stream_unit: RTL and testbench

Streaming, parametrised successor to the single-element pooling ALU. It performs non-overlapping POOL×POOL max, min or average pooling over a row-major feature map, processing LANES channels in parallel per beat. Input and output use valid/ready handshakes, so the block sits between the convolution output stream and the activation write-back buffer. A one-row partial-result buffer replaces the neighbour-link (up/down) wiring of the previous generation.

---
 rtl/pool_stream_unit.sv | 157 +++++++++++++++
 tb/tb_pool_stream_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream_unit.sv
// Streaming POOLxPOOL max/min/average pooling over a row-major feature map, LANES channels per beat.
// A one-row partial buffer holds per-window running results until each window's last pixel arrives.
module pool_stream_unit #(
  parameter int W     = 8,
  parameter int LANES = 4,
  parameter int POOL  = 2,
  parameter int MAX_W = 64,
  localparam int CW   = $clog2(MAX_W) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_start,
  input  logic [1:0]         cfg_mode,
  input  logic [CW-1:0]      cfg_width,
  input  logic [15:0]        cfg_height,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int LP = $clog2(POOL);
  localparam int SH = 2 * LP;
  localparam int AW = W + SH;
  localparam int NE = MAX_W / POOL;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_MAX = 2'b00, M_MIN = 2'b01, M_AVG = 2'b10, M_RSV = 2'b11} mode_t;

  state_t        state;
  mode_t         mode;
  logic [CW-1:0] width;
  logic [CW-1:0] col;
  logic [15:0]   height;
  logic [15:0]   row;
  logic          final_pending;

  logic [AW-1:0] pbuf [NE][LANES];

  logic               accept;
  logic               first_px;
  logic               last_px;
  logic               frame_end;
  logic               cfg_ok;
  logic [IW-1:0]      idx;
  logic [AW-1:0]      comb_val [LANES];
  logic [LANES*W-1:0] result;

  // Same-cycle pass-through: a result being drained frees the register for a new one.
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign idx       = IW'(col >> LP);
  assign first_px  = (row[LP-1:0] == '0) && (col[LP-1:0] == '0);
  assign last_px   = (row[LP-1:0] == LP'(POOL - 1)) && (col[LP-1:0] == LP'(POOL - 1));
  assign frame_end = (row == height - 16'd1) && (col == width - CW'(1));

  assign cfg_ok = (cfg_width != '0) && (cfg_width <= CW'(MAX_W)) && (cfg_width[LP-1:0] == '0) &&
                  (cfg_height != '0) && (cfg_height[LP-1:0] == '0);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    result = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [W-1:0]  pix;
      logic [AW-1:0] entry;
      pix   = in_data[l*W +: W];
      entry = pbuf[idx][l];
      case (mode)
        M_MIN:   comb_val[l] = (pix < entry[W-1:0]) ? AW'(pix) : AW'(entry[W-1:0]);
        M_AVG:   comb_val[l] = entry + AW'(pix);
        default: comb_val[l] = (pix > entry[W-1:0]) ? AW'(pix) : AW'(entry[W-1:0]);
      endcase
      // The running sum fits in AW bits, so the shifted average always fits in W bits.
      result[l*W +: W] = (mode == M_AVG) ? comb_val[l][SH +: W] : comb_val[l][W-1:0];
    end
  end

  // NOTE: the partial buffer has no reset; each entry is loaded by a window's first pixel before it is read.
  always_ff @(posedge clk) begin
    if (accept && !last_px) begin
      for (int l = 0; l < LANES; l++) begin
        pbuf[idx][l] <= first_px ? AW'(in_data[l*W +: W]) : comb_val[l];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      mode          <= M_MAX;
      width         <= '0;
      height        <= '0;
      col           <= '0;
      row           <= '0;
      final_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_ok) begin
              mode          <= mode_t'(cfg_mode);
              width         <= cfg_width;
              height        <= cfg_height;
              col           <= '0;
              row           <= '0;
              final_pending <= 1'b0;
              busy          <= 1'b1;
              state         <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col == width - CW'(1)) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + CW'(1);
            end
            if (frame_end) final_pending <= 1'b1;
          end
          if (accept && last_px) begin
            out_valid <= 1'b1;
            out_data  <= result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          // The frame's last pixel is window-final, so its result is the one in the register now.
          if (final_pending && out_valid && out_ready) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Self-checking bench for pool_stream_unit: directed scenarios plus randomized frames checked
// against a window-by-window arithmetic reference model.
module tb_pool_stream_unit;

  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int MAX_W = 64;
  localparam int CW    = $clog2(MAX_W) + 1;
  localparam int DW    = LANES * W;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_start2, cfg_start4;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_width;
  logic [15:0]   cfg_height;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          ir2, ov2, busy2, done2, err2;
  logic [DW-1:0] od2;
  logic          ir4, ov4, busy4, done4, err4;
  logic [DW-1:0] od4;

  bit            sel4;
  logic          o_in_ready, o_valid, o_busy, o_done, o_err;
  logic [DW-1:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] px [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int done_cnt, stall_bad, ready_bad, ready_low, err_seen;
  bit timed_out;
  logic busy_after_start, busy_at_done;

  always #5 clk = ~clk;

  pool_stream_unit #(.W(W), .LANES(LANES), .POOL(2), .MAX_W(MAX_W)) dut2 (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start2), .cfg_mode(cfg_mode),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .in_valid(in_valid),
    .in_ready(ir2), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .busy(busy2), .done(done2), .cfg_err(err2));

  pool_stream_unit #(.W(W), .LANES(LANES), .POOL(4), .MAX_W(MAX_W)) dut4 (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start4), .cfg_mode(cfg_mode),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .in_valid(in_valid),
    .in_ready(ir4), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .busy(busy4), .done(done4), .cfg_err(err4));

  assign o_in_ready = sel4 ? ir4 : ir2;
  assign o_valid    = sel4 ? ov4 : ov2;
  assign o_busy     = sel4 ? busy4 : busy2;
  assign o_done     = sel4 ? done4 : done2;
  assign o_err      = sel4 ? err4 : err2;
  assign o_data     = sel4 ? od4 : od2;

  // Reference: walk every pooled window and reduce its p*p pixels per lane with plain integers.
  function automatic void build_exp(input int p, input int mode, input int wdt, input int hgt);
    exp_q.delete();
    for (int wr = 0; wr < hgt / p; wr++) begin
      for (int wc = 0; wc < wdt / p; wc++) begin
        logic [DW-1:0] beat;
        beat = '0;
        for (int l = 0; l < LANES; l++) begin
          int acc;
          acc = (mode == 1) ? 1 << W : 0;
          for (int dr = 0; dr < p; dr++) begin
            for (int dc = 0; dc < p; dc++) begin
              logic [DW-1:0] pxw;
              int v;
              pxw = px[(wr * p + dr) * wdt + wc * p + dc];
              v = int'(pxw[l*W +: W]);
              if (mode == 1)      acc = (v < acc) ? v : acc;
              else if (mode == 2) acc = acc + v;
              else                acc = (v > acc) ? v : acc;
            end
          end
          if (mode == 2) acc = acc / (p * p);
          beat[l*W +: W] = W'(acc);
        end
        exp_q.push_back(beat);
      end
    end
  endfunction

  task automatic run_frame(input bit use4, input int mode, input int wdt, input int hgt,
                           input int stall_len, input int vpct, input int rpct);
    int n, idx, cyc, post, stall_left;
    bit stall_started, prev_hold;
    logic [DW-1:0] prev_data;
    n = wdt * hgt;
    got_q.delete();
    done_cnt = 0; stall_bad = 0; ready_bad = 0; ready_low = 0; err_seen = 0;
    sel4 = use4;
    @(negedge clk);
    cfg_mode   = 2'(mode);
    cfg_width  = CW'(wdt);
    cfg_height = 16'(hgt);
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    if (use4) cfg_start4 = 1'b1; else cfg_start2 = 1'b1;
    @(negedge clk);
    cfg_start2 = 1'b0;
    cfg_start4 = 1'b0;
    #1 busy_after_start = o_busy;
    idx = 0; cyc = 0; post = 0; stall_left = 0;
    stall_started = 1'b0; prev_hold = 1'b0; prev_data = '0;
    busy_at_done = 1'bx;
    while (cyc < 4000 && post < 4) begin
      @(negedge clk);
      if (stall_len > 0 && !stall_started && o_valid === 1'b1) begin
        stall_left = stall_len;
        stall_started = 1'b1;
      end
      if (idx < n && int'($urandom_range(0, 99)) < vpct) begin
        in_valid = 1'b1;
        in_data  = px[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = int'($urandom_range(0, 99)) < rpct;
      end
      #1;
      if (prev_hold && (o_valid !== 1'b1 || o_data !== prev_data)) stall_bad++;
      if (o_valid && !out_ready) begin
        ready_low++;
        if (o_in_ready !== 1'b0) ready_bad++;
      end
      prev_hold = o_valid && !out_ready;
      prev_data = o_data;
      if (o_valid && out_ready) got_q.push_back(o_data);
      if (in_valid && o_in_ready) idx++;
      if (o_done === 1'b1) begin
        done_cnt++;
        busy_at_done = o_busy;
      end
      if (o_err === 1'b1) err_seen++;
      if (done_cnt > 0) post++;
      cyc++;
    end
    timed_out = (done_cnt == 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      px[i] = DW'($urandom);
      px[i][W-1:0] = W'(i);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ir2 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", ir2); end
    n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", ov2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy2); end
    n_cmp++; if (done2 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done2); end
    n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %b expected 0", err2); end
    n_cmp++; if (od2 !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", od2); end
    n_cmp++; if (od4 !== '0 || ov4 !== 1'b0) begin n_bad++; $display("FAIL reset_pool4_out: got %b/%h expected 0/0", ov4, od4); end
    @(negedge clk);
    rstn = 1'b1;
    in_valid = 1'b1;
    in_data = DW'($urandom);
    @(negedge clk);
    #1;
    n_cmp++; if (ir2 !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready: got %b expected 0", ir2); end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int nexp);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL %s_timeout: got no done expected done", name); end
    n_cmp++; if (got_q.size() != nexp) begin n_bad++; $display("FAIL %s_beats: got %0d expected %0d", name, got_q.size(), nexp); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL %s_beat%0d: got %h expected %h", name, k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_max_ramp();
    int l0 [4] = '{5, 7, 13, 15};
    fill_ramp();
    build_exp(2, 0, 4, 4);
    run_frame(1'b0, 0, 4, 4, 0, 100, 100);
    check_frame("max_ramp", 4);
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++;
      if (got_q[k][W-1:0] !== W'(l0[k])) begin n_bad++; $display("FAIL max_lane0_%0d: got %0d expected %0d", k, got_q[k][W-1:0], l0[k]); end
    end
    n_cmp++; if (busy_after_start !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b expected 1", busy_after_start); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %b expected 0", busy_at_done); end
  endtask

  task automatic test_avg();
    int l0 [4] = '{2, 4, 10, 12};
    fill_ramp();
    build_exp(2, 2, 4, 4);
    run_frame(1'b0, 2, 4, 4, 0, 100, 100);
    check_frame("avg_ramp", 4);
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++;
      if (got_q[k][W-1:0] !== W'(l0[k])) begin n_bad++; $display("FAIL avg_lane0_%0d: got %0d expected %0d", k, got_q[k][W-1:0], l0[k]); end
    end
    for (int i = 0; i < 16; i++) px[i] = '1;
    run_frame(1'b0, 2, 4, 4, 0, 100, 100);
    n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL avg_sat_beats: got %0d expected 4", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== {DW{1'b1}}) begin n_bad++; $display("FAIL avg_sat_beat%0d: got %h expected all ones", k, got_q[k]); end
    end
  endtask

  task automatic test_min_pool4();
    int l3 [2] = '{173, 169};
    for (int i = 0; i < 32; i++) begin
      px[i] = DW'($urandom);
      px[i][3*W +: W] = W'(200 - i);
    end
    build_exp(4, 1, 8, 4);
    run_frame(1'b1, 1, 8, 4, 0, 100, 100);
    check_frame("min_pool4", 2);
    for (int k = 0; k < got_q.size() && k < 2; k++) begin
      n_cmp++;
      if (got_q[k][3*W +: W] !== W'(l3[k])) begin n_bad++; $display("FAIL min_lane3_%0d: got %0d expected %0d", k, got_q[k][3*W +: W], l3[k]); end
    end
    sel4 = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) px[i] = DW'($urandom);
    build_exp(2, 0, 4, 4);
    run_frame(1'b0, 0, 4, 4, 5, 100, 100);
    check_frame("backpressure", 4);
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_hold_stable: got %0d changes expected 0", stall_bad); end
    n_cmp++; if (ready_low < 5) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d expected at least 5", ready_low); end
    n_cmp++; if (ready_bad != 0) begin n_bad++; $display("FAIL bp_in_ready_low: got %0d high cycles expected 0", ready_bad); end
  endtask

  task automatic test_cfg_err();
    int bw [3] = '{5, MAX_W + 2, 4};
    int bh [3] = '{4, 4, 0};
    for (int c = 0; c < 3; c++) begin
      int errs, busys;
      errs = 0; busys = 0;
      sel4 = 1'b0;
      @(negedge clk);
      cfg_mode = 2'b00;
      cfg_width = CW'(bw[c]);
      cfg_height = 16'(bh[c]);
      cfg_start2 = 1'b1;
      @(negedge clk);
      cfg_start2 = 1'b0;
      for (int t = 0; t < 4; t++) begin
        if (t > 0) @(negedge clk);
        #1;
        if (err2 === 1'b1) errs++;
        if (busy2 !== 1'b0) busys++;
      end
      n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL cfg_err_pulse%0d: got %0d expected 1", c, errs); end
      n_cmp++; if (busys != 0) begin n_bad++; $display("FAIL cfg_err_busy%0d: got %0d expected 0", c, busys); end
    end
    fill_ramp();
    build_exp(2, 0, 4, 4);
    run_frame(1'b0, 0, 4, 4, 0, 100, 100);
    check_frame("after_cfg_err", 4);
    n_cmp++; if (err_seen != 0) begin n_bad++; $display("FAIL legal_cfg_err: got %0d expected 0", err_seen); end
  endtask

  task automatic test_reset_midrun();
    int idx, cyc;
    sel4 = 1'b0;
    for (int i = 0; i < 16; i++) px[i] = {LANES{8'hF0}} | DW'($urandom);
    @(negedge clk);
    cfg_mode = 2'b00; cfg_width = CW'(4); cfg_height = 16'd4;
    cfg_start2 = 1'b1;
    @(negedge clk);
    cfg_start2 = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 100) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = px[idx]; out_ready = 1'b1;
      #1;
      if (ir2) idx++;
      cyc++;
    end
    n_cmp++; if (idx != 6) begin n_bad++; $display("FAIL midrun_fill: got %0d beats expected 6", idx); end
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_cmp++; if (ov2 !== 1'b0 || od2 !== '0) begin n_bad++; $display("FAIL midrun_out_clear: got %b/%h expected 0/0", ov2, od2); end
    n_cmp++; if (busy2 !== 1'b0 || ir2 !== 1'b0) begin n_bad++; $display("FAIL midrun_busy_clear: got %b/%b expected 0/0", busy2, ir2); end
    @(negedge clk);
    rstn = 1'b1;
    fill_ramp();
    build_exp(2, 0, 4, 4);
    run_frame(1'b0, 0, 4, 4, 0, 100, 100);
    check_frame("after_reset", 4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 9; f++) begin
      bit use4;
      int p, mode, wdt, hgt;
      use4 = (f >= 6);
      p = use4 ? 4 : 2;
      mode = int'($urandom_range(0, 3));
      wdt = p * int'($urandom_range(1, use4 ? 4 : 8));
      hgt = p * int'($urandom_range(1, 2 * (4 / p) + (use4 ? 0 : 2)));
      for (int i = 0; i < wdt * hgt; i++) px[i] = DW'($urandom);
      build_exp(p, mode, wdt, hgt);
      run_frame(use4, mode, wdt, hgt, 0, 75, 60);
      check_frame($sformatf("rand%0d", f), exp_q.size());
      n_cmp++; if (stall_bad != 0 || ready_bad != 0) begin n_bad++; $display("FAIL rand%0d_handshake: got %0d/%0d expected 0/0", f, stall_bad, ready_bad); end
    end
    sel4 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cfg_start2 = 1'b0; cfg_start4 = 1'b0; cfg_mode = '0;
    cfg_width = '0; cfg_height = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; sel4 = 1'b0;
    test_reset();
    test_max_ramp();
    test_avg();
    test_min_pool4();
    test_backpressure();
    test_cfg_err();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
